// File: rtl/uart_frame_rx.sv
// Wide-frame UART receiver: start bit, FRAME_WIDTH data bits LSB first, stop bit.
// Delivers the payload on a ready/valid port and pulses framing / overrun errors.
module uart_frame_rx #(
  parameter int FRAME_WIDTH      = 22,
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int CNT_WIDTH        = $clog2(CLOCKS_PER_PULSE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   u_rx,
  output logic [FRAME_WIDTH-1:0] rdata,
  output logic                   rvalid,
  input  logic                   rready,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int HALF      = CLOCKS_PER_PULSE / 2;
  localparam int IDX_WIDTH = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

  localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(HALF - 1);
  localparam logic [CNT_WIDTH-1:0] BIT_LAST  = CNT_WIDTH'(CLOCKS_PER_PULSE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST  = IDX_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE   = IDX_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RECOVER = 3'd4
  } state_e;

  logic                   rx_meta_q, rx_sync_q;
  logic                   rx_s;
  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   timer_q, timer_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [FRAME_WIDTH-1:0] shift_q, shift_d;
  logic [FRAME_WIDTH-1:0] rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   busy_q, busy_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   good_s;

  // Two-flop synchroniser on the asynchronous line; idle level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= u_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rx_s = rx_sync_q;

  // Frame state, bit timing, shift register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state logic: bit-centre sampling, stop check and output handshake.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    good_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          timer_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        // Re-check the line at mid start bit so short low glitches are rejected.
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[FRAME_WIDTH-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
            good_s  = 1'b1;
          end else begin
            state_d = S_RECOVER;
            ferr_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      S_RECOVER: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RECOVER;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase

    // A commit may coincide with a consumer accept; the new word then replaces the old.
    if (good_s) begin
      if (!rvalid_q || rready) begin
        rdata_d  = shift_q;
        rvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed scenarios plus randomized frames,
// checked each cycle against a time-stamp based behavioural receiver model.
module tb_uart_frame_rx;

  localparam int FW   = 22;
  localparam int CPP  = 16;
  localparam int HALF = CPP / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          u_rx;
  logic          rready;
  logic [FW-1:0] rdata;
  logic          rvalid, busy, frame_err, overrun;

  always #5 clk = ~clk;

  uart_frame_rx #(.FRAME_WIDTH(FW), .CLOCKS_PER_PULSE(CPP)) dut (
    .clk(clk), .rst(rst), .u_rx(u_rx), .rdata(rdata), .rvalid(rvalid),
    .rready(rready), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;

  // Model state: mode 0 = idle, 1 = inside a frame (timed from t0), 2 = waiting for line high
  int            m_mode, m_t0;
  logic [FW-1:0] m_word, m_rdata;
  logic          m_sync1, m_sync2;
  logic          m_rvalid, m_busy, m_ferr, m_ovr;

  int            busy_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, last_rise = -1;
  logic          prev_rvalid = 1'b0;
  logic [FW-1:0] delivered[$];
  bit            rand_rready = 1'b0;

  task automatic model_reset();
    m_mode = 0; m_t0 = 0; m_word = '0; m_rdata = '0;
    m_sync1 = 1'b1; m_sync2 = 1'b1;
    m_rvalid = 1'b0; m_busy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  // Outputs after the edge that closes cycle c, from elapsed time since the falling edge.
  task automatic model_edge(input int c);
    logic r;
    int   d, k;
    bit   commit;
    if (rst) begin
      model_reset();
      return;
    end
    r = m_sync2; m_sync2 = m_sync1; m_sync1 = u_rx;
    m_ferr = 1'b0; m_ovr = 1'b0; commit = 1'b0;
    if (m_mode == 0) begin
      if (!r) begin m_mode = 1; m_t0 = c; end
    end else if (m_mode == 1) begin
      d = c - m_t0;
      if (d == HALF) begin
        if (r) m_mode = 0;
      end else if (d > HALF && ((d - HALF) % CPP) == 0) begin
        k = (d - HALF) / CPP - 1;
        if (k < FW) m_word[k] = r;
        else if (r) begin commit = 1'b1; m_mode = 0; end
        else begin m_ferr = 1'b1; m_mode = 2; end
      end
    end else begin
      if (r) m_mode = 0;
    end
    if (commit) begin
      if (!m_rvalid || rready) begin m_rdata = m_word; m_rvalid = 1'b1; end
      else m_ovr = 1'b1;
    end else if (m_rvalid && rready) begin
      m_rvalid = 1'b0;
    end
    m_busy = (m_mode != 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_outputs();
    bit bad = 1'b0;
    vectors++;
    if (rdata !== m_rdata) begin bad = 1'b1; $display("FAIL rdata cyc=%0d got %h expected %h", cyc, rdata, m_rdata); end
    if (rvalid !== m_rvalid) begin bad = 1'b1; $display("FAIL rvalid cyc=%0d got %b expected %b", cyc, rvalid, m_rvalid); end
    if (busy !== m_busy) begin bad = 1'b1; $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, m_busy); end
    if (frame_err !== m_ferr) begin bad = 1'b1; $display("FAIL frame_err cyc=%0d got %b expected %b", cyc, frame_err, m_ferr); end
    if (overrun !== m_ovr) begin bad = 1'b1; $display("FAIL overrun cyc=%0d got %b expected %b", cyc, overrun, m_ovr); end
    if (bad) miscompares++;
    if (busy === 1'b1) busy_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (rvalid === 1'b1 && prev_rvalid !== 1'b1) last_rise = cyc;
    prev_rvalid = rvalid;
  endtask

  // One clock: log an accepted word, step the model at the edge, compare at the falling edge.
  task automatic tick();
    if (rvalid === 1'b1 && rready === 1'b1) delivered.push_back(rdata);
    @(posedge clk);
    model_edge(cyc);
    cyc++;
    @(negedge clk);
    compare_outputs();
    if (rand_rready) rready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    u_rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_flags", 32'({frame_err, overrun}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Even-numbered bits (start first) last per_a cycles, odd ones per_b; cut >= 0 resets mid-frame.
  task automatic send_frame(input logic [FW-1:0] w, input int per_a, input int per_b,
                            input logic stop_val, input int cut);
    int   el = 0;
    int   p;
    logic bitv;
    start_cyc = cyc;
    for (int b = 0; b < FW + 2; b++) begin
      bitv = (b == 0) ? 1'b0 : (b == FW + 1) ? stop_val : w[b-1];
      p = (b % 2 == 0) ? per_a : per_b;
      for (int j = 0; j < p; j++) begin
        if (el == cut) begin
          u_rx = 1'b1;
          do_reset();
          return;
        end
        u_rx = bitv;
        tick();
        el++;
      end
    end
    u_rx = 1'b1;
  endtask

  function automatic logic [FW-1:0] del_at(input int i);
    if (i < delivered.size()) return delivered[i];
    else return '1;
  endfunction

  int b_busy, b_f, b_o, b_d;

  task automatic snap();
    b_busy = busy_cnt; b_f = ferr_cnt; b_o = ovr_cnt; b_d = delivered.size();
  endtask

  initial begin
    rst = 1'b1; u_rx = 1'b1; rready = 1'b0;
    model_reset();
    repeat (3) tick();
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    idle(5);

    // Ideal single frame, consumer always ready
    rready = 1'b1;
    snap();
    send_frame(22'h2ABC5A, CPP, CPP, 1'b1, -1);
    idle(10);
    check("t1_count", 32'(delivered.size() - b_d), 32'd1);
    check("t1_data", 32'(del_at(b_d)), 32'h2ABC5A);
    check("t1_latency", 32'(last_rise), 32'(start_cyc + 2 + 1 + HALF + 23 * CPP));
    check("t1_busy_span", 32'(busy_cnt - b_busy), 32'(HALF + 23 * CPP));
    check("t1_flags", 32'((ferr_cnt - b_f) + (ovr_cnt - b_o)), 32'd0);

    // Back-to-back frames with the consumer stalled
    rready = 1'b0;
    snap();
    send_frame(22'h000001, CPP, CPP, 1'b1, -1);
    send_frame(22'h3FFFFF, CPP, CPP, 1'b1, -1);
    idle(10);
    check("t2_overrun", 32'(ovr_cnt - b_o), 32'd1);
    check("t2_rdata_held", 32'(rdata), 32'h000001);
    check("t2_rvalid_held", 32'(rvalid), 32'd1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    tick();
    check("t2_rvalid_drop", 32'(rvalid), 32'd0);
    check("t2_count", 32'(delivered.size() - b_d), 32'd1);
    check("t2_data", 32'(del_at(b_d)), 32'h000001);

    // Framing error, long low line, then a clean frame
    rready = 1'b1;
    snap();
    send_frame(22'h155555, CPP, CPP, 1'b0, -1);
    u_rx = 1'b0;
    repeat (100) tick();
    idle(20);
    send_frame(22'h0000A5, CPP, CPP, 1'b1, -1);
    idle(20);
    check("t3_frame_err", 32'(ferr_cnt - b_f), 32'd1);
    check("t3_count", 32'(delivered.size() - b_d), 32'd1);
    check("t3_data", 32'(del_at(b_d)), 32'h0000A5);

    // Short low glitch on an idle line
    snap();
    u_rx = 1'b0;
    repeat (5) tick();
    idle(30);
    check("t4_busy_span", 32'(busy_cnt - b_busy), 32'(HALF));
    check("t4_count", 32'(delivered.size() - b_d), 32'd0);
    check("t4_flags", 32'((ferr_cnt - b_f) + (ovr_cnt - b_o)), 32'd0);

    // Reset in the middle of data bit 10, then a clean frame
    snap();
    send_frame(22'h012345, CPP, CPP, 1'b1, CPP * 11 + HALF);
    idle(20);
    send_frame(22'h012345, CPP, CPP, 1'b1, -1);
    idle(20);
    check("t5_count", 32'(delivered.size() - b_d), 32'd1);
    check("t5_data", 32'(del_at(b_d)), 32'h012345);

    // Per-bit timing jitter of one cycle in both directions
    snap();
    send_frame(22'h2ABC5A, CPP + 1, CPP - 1, 1'b1, -1);
    idle(20);
    send_frame(22'h2ABC5A, CPP - 1, CPP + 1, 1'b1, -1);
    idle(20);
    check("t6_count", 32'(delivered.size() - b_d), 32'd2);
    check("t6_data_a", 32'(del_at(b_d)), 32'h2ABC5A);
    check("t6_data_b", 32'(del_at(b_d + 1)), 32'h2ABC5A);

    // Randomized frames, jitter, stop errors, gaps and consumer stalls
    rand_rready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      logic [FW-1:0] w;
      int            pa, pb;
      w  = FW'($urandom);
      pa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(CPP - 1, CPP + 1)) : CPP;
      pb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(CPP - 1, CPP + 1)) : CPP;
      send_frame(w, pa, pb, ($urandom_range(0, 7) != 0), -1);
      idle(int'($urandom_range(0, 40)));
    end
    rand_rready = 1'b0;
    rready = 1'b1;
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
